// File: rtl/spi_xfer_ctrl.sv
// SPI transfer sequencer: generates SCLK/SS_N and per-bit strobes for a
// downstream shift register. All outputs are registered.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ss_n high, sclk at captured idle level, waiting for start
// SETUP | ss_n asserted, downstream per-transfer state cleared
// LOAD  | downstream tx string loaded, divider cleared
// RUN   | SCLK toggling every clkdiv+1 clk cycles, bit strobes issued
// HOLD  | sclk parked at idle level, ss_n held low for clkdiv+1 cycles
// DONE  | ss_n released, done pulse, then back to IDLE
module spi_xfer_ctrl #(
    parameter int DIV_W = 8,
    parameter int CYC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [DIV_W-1:0] clkdiv,
    input  logic             cpol,
    input  logic [CYC_W-1:0] xfer_cycles,
    output logic             sclk,
    output logic             ss_n,
    output logic             sclk_en,
    output logic             latchout_en,
    output logic             latchin_en,
    output logic             setup_rst,
    output logic             loadtxdata_en,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        LOAD  = 3'd2,
        RUN   = 3'd3,
        HOLD  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] clkdiv_q;
    logic [CYC_W-1:0] cyc_q;
    logic             cpol_q;
    logic [DIV_W-1:0] div_cnt;
    logic [CYC_W-1:0] lead_cnt;

    // Sequencer: state, captured config, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            clkdiv_q      <= '0;
            cyc_q         <= '0;
            cpol_q        <= 1'b0;
            div_cnt       <= '0;
            lead_cnt      <= '0;
            sclk          <= 1'b0;
            ss_n          <= 1'b1;
            sclk_en       <= 1'b0;
            latchout_en   <= 1'b0;
            latchin_en    <= 1'b0;
            setup_rst     <= 1'b0;
            loadtxdata_en <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            // Strobes default low so each is a single-cycle pulse.
            latchout_en   <= 1'b0;
            latchin_en    <= 1'b0;
            setup_rst     <= 1'b0;
            loadtxdata_en <= 1'b0;
            done          <= 1'b0;

            if (abort && (state != IDLE)) begin
                state    <= IDLE;
                ss_n     <= 1'b1;
                sclk     <= cpol_q;
                sclk_en  <= 1'b0;
                busy     <= 1'b0;
                div_cnt  <= '0;
                lead_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        ss_n    <= 1'b1;
                        sclk    <= cpol_q;
                        sclk_en <= 1'b0;
                        busy    <= 1'b0;
                        // A start coinciding with abort is dropped.
                        if (start && !abort) begin
                            clkdiv_q <= clkdiv;
                            cpol_q   <= cpol;
                            cyc_q    <= xfer_cycles;
                            sclk     <= cpol;
                            busy     <= 1'b1;
                            div_cnt  <= '0;
                            lead_cnt <= '0;
                            if (xfer_cycles == '0) begin
                                // Empty transfer: never touch the bus.
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state     <= SETUP;
                                ss_n      <= 1'b0;
                                setup_rst <= 1'b1;
                            end
                        end
                    end
                    SETUP: begin
                        state         <= LOAD;
                        loadtxdata_en <= 1'b1;
                        div_cnt       <= '0;
                    end
                    LOAD: begin
                        // First bit is pre-driven before the first SCLK edge.
                        state       <= RUN;
                        sclk_en     <= 1'b1;
                        latchout_en <= 1'b1;
                        div_cnt     <= '0;
                    end
                    RUN: begin
                        if (div_cnt == clkdiv_q) begin
                            div_cnt <= '0;
                            if (sclk == cpol_q) begin
                                sclk       <= ~cpol_q;
                                latchin_en <= 1'b1;
                                lead_cnt   <= lead_cnt + 1'b1;
                            end else begin
                                sclk <= cpol_q;
                                // The trailing edge of the final bit shifts
                                // nothing out; it ends the clocking phase.
                                if (lead_cnt == cyc_q) begin
                                    state   <= HOLD;
                                    sclk_en <= 1'b0;
                                end else begin
                                    latchout_en <= 1'b1;
                                end
                            end
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    HOLD: begin
                        if (div_cnt == clkdiv_q) begin
                            state   <= DONE;
                            ss_n    <= 1'b1;
                            done    <= 1'b1;
                            div_cnt <= '0;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state   <= IDLE;
                        ss_n    <= 1'b1;
                        sclk    <= cpol_q;
                        sclk_en <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl: a negedge monitor accumulates event
// counts and timestamps, and each scenario compares them to hand-derived values.
module tb_spi_xfer_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, abort, cpol;
    logic [7:0] clkdiv, xfer_cycles;
    logic       sclk, ss_n, sclk_en, latchout_en, latchin_en;
    logic       setup_rst, loadtxdata_en, busy, done;
    logic [8:0] outs;

    int n_chk = 0;
    int n_err = 0;

    int tick = 0;
    int n_lin, n_lout, n_done, n_setup, n_load, n_tog, n_ssn_low, n_en, n_both, n_low;
    int t_setup, t_load, t_first_lin, t_last_lin, t_last_edge, t_done, t_start;
    logic prev_sclk, prev_ssn;

    spi_xfer_ctrl #(.DIV_W(8), .CYC_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .clkdiv(clkdiv), .cpol(cpol), .xfer_cycles(xfer_cycles),
        .sclk(sclk), .ss_n(ss_n), .sclk_en(sclk_en),
        .latchout_en(latchout_en), .latchin_en(latchin_en),
        .setup_rst(setup_rst), .loadtxdata_en(loadtxdata_en),
        .busy(busy), .done(done)
    );

    assign outs = {sclk, ss_n, sclk_en, latchout_en, latchin_en,
                   setup_rst, loadtxdata_en, busy, done};

    always #5 clk = ~clk;

    // Monitor: sample outputs on the falling edge and accumulate statistics.
    always @(negedge clk) begin
        tick = tick + 1;
        if (latchin_en) begin
            if (n_lin == 0) t_first_lin = tick;
            t_last_lin = tick;
            n_lin = n_lin + 1;
        end
        if (latchout_en) n_lout = n_lout + 1;
        if (latchin_en && latchout_en) n_both = n_both + 1;
        if (done) begin n_done = n_done + 1; t_done = tick; end
        if (setup_rst) begin n_setup = n_setup + 1; t_setup = tick; end
        if (loadtxdata_en) begin n_load = n_load + 1; t_load = tick; end
        if (!ss_n) n_ssn_low = n_ssn_low + 1;
        if (!ss_n && !sclk) n_low = n_low + 1;
        if (sclk_en) n_en = n_en + 1;
        if (!ss_n && !prev_ssn && (sclk != prev_sclk)) begin
            n_tog = n_tog + 1;
            t_last_edge = tick;
        end
        prev_sclk = sclk;
        prev_ssn  = ss_n;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        n_lin = 0; n_lout = 0; n_done = 0; n_setup = 0; n_load = 0;
        n_tog = 0; n_ssn_low = 0; n_en = 0; n_both = 0; n_low = 0;
        t_setup = -1; t_load = -1; t_first_lin = -1; t_last_lin = -1;
        t_last_edge = -1; t_done = -1;
        prev_sclk = sclk; prev_ssn = ss_n;
    endtask

    task automatic pulse_start(input int div, input logic pol, input int cyc);
        @(negedge clk); #1;
        clkdiv = 8'(div); cpol = pol; xfer_cycles = 8'(cyc);
        start = 1'b1;
        t_start = tick;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy) break;
            @(negedge clk); #1;
        end
        chk(tag, busy, 0);
    endtask

    task automatic wait_lin(input string tag, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (n_lin >= n) break;
            @(negedge clk); #1;
        end
        chk(tag, n_lin, n);
    endtask

    initial begin
        int k0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; cpol = 1'b0;
        clkdiv = 8'd0; xfer_cycles = 8'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outs", outs, 9'b0_1000_0000);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("idle_outs", outs, 9'b0_1000_0000);

        // clkdiv=1, cpol=0, 8 cycles
        clear_stats();
        pulse_start(1, 1'b0, 8);
        wait_idle("t1_timeout", 200);
        chk("t1_setup_time", t_setup - t_start, 1);
        chk("t1_load_time", t_load - t_setup, 1);
        chk("t1_setup_cnt", n_setup, 1);
        chk("t1_load_cnt", n_load, 1);
        chk("t1_first_lead", t_first_lin - t_start, 5);
        chk("t1_lead_span", t_last_lin - t_first_lin, 28);
        chk("t1_latchin", n_lin, 8);
        chk("t1_latchout", n_lout, 8);
        chk("t1_toggles", n_tog, 16);
        chk("t1_done_cnt", n_done, 1);
        chk("t1_done_after_fall", t_done - t_last_edge, 2);
        chk("t1_ssn_low", n_ssn_low, 36);
        chk("t1_sclk_en", n_en, 32);
        chk("t1_overlap", n_both, 0);
        chk("t1_idle_outs", outs, 9'b0_1000_0000);

        // clkdiv=0, cpol=1, single cycle
        clear_stats();
        pulse_start(0, 1'b1, 1);
        wait_idle("t2_timeout", 100);
        chk("t2_latchin", n_lin, 1);
        chk("t2_latchout", n_lout, 1);
        chk("t2_toggles", n_tog, 2);
        chk("t2_low_width", n_low, 1);
        chk("t2_done_cnt", n_done, 1);
        chk("t2_done_time", t_done - t_start, 6);
        chk("t2_ssn_low", n_ssn_low, 5);
        chk("t2_idle_sclk", sclk, 1);

        // zero-length transfer
        clear_stats();
        pulse_start(3, 1'b1, 0);
        wait_idle("t3_timeout", 20);
        chk("t3_done_time", t_done - t_start, 1);
        chk("t3_done_cnt", n_done, 1);
        chk("t3_ssn_low", n_ssn_low, 0);
        chk("t3_setup_cnt", n_setup, 0);
        chk("t3_toggles", n_tog, 0);

        // start during RUN is ignored
        clear_stats();
        pulse_start(2, 1'b0, 4);
        k0 = t_start;
        wait_lin("t4_wait", 1, 50);
        pulse_start(0, 1'b1, 9);
        wait_idle("t4_timeout", 200);
        chk("t4_lead_span", t_last_lin - t_first_lin, 18);
        chk("t4_latchin", n_lin, 4);
        chk("t4_latchout", n_lout, 4);
        chk("t4_done_cnt", n_done, 1);
        chk("t4_done_time", t_done - k0, 30);
        chk("t4_ssn_low", n_ssn_low, 29);
        chk("t4_idle_sclk", sclk, 0);
        repeat (5) @(negedge clk);
        #1;
        chk("t4_no_restart", busy, 0);

        // abort after third latchin
        clear_stats();
        pulse_start(1, 1'b0, 16);
        wait_lin("t5_wait", 3, 100);
        abort = 1'b1;
        @(negedge clk); #1;
        abort = 1'b0;
        chk("t5_abort_outs", outs, 9'b0_1000_0000);
        repeat (20) @(negedge clk);
        #1;
        chk("t5_no_done", n_done, 0);
        chk("t5_latchin", n_lin, 3);
        clear_stats();
        pulse_start(1, 1'b0, 16);
        wait_idle("t5b_timeout", 300);
        chk("t5b_latchin", n_lin, 16);
        chk("t5b_latchout", n_lout, 16);
        chk("t5b_toggles", n_tog, 32);
        chk("t5b_done_cnt", n_done, 1);
        chk("t5b_ssn_low", n_ssn_low, 68);
        chk("t5b_overlap", n_both, 0);

        // start coinciding with abort in IDLE is discarded
        clear_stats();
        @(negedge clk); #1;
        clkdiv = 8'd1; cpol = 1'b0; xfer_cycles = 8'd4;
        start = 1'b1; abort = 1'b1;
        @(negedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("t6_busy", busy, 0);
        repeat (3) @(negedge clk);
        #1;
        chk("t6_setup_cnt", n_setup, 0);
        chk("t6_ssn_low", n_ssn_low, 0);

        // rst mid-RUN
        clear_stats();
        pulse_start(1, 1'b1, 8);
        wait_lin("t7_wait", 2, 100);
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        chk("t7_rst_outs", outs, 9'b0_1000_0000);
        repeat (20) @(negedge clk);
        #1;
        chk("t7_no_done", n_done, 0);
        chk("t7_idle_outs", outs, 9'b0_1000_0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
